sonar_sweep_ctrl: RTL

SONAR_SWEEP_CTRL -- requirements
Module: sonar_sweep_ctrl

---
 rtl/sonar_ctrl_pkg.sv | 36 +++
 rtl/contador_m.sv | 34 +++
 rtl/sonar_sweep_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/sonar_ctrl_pkg.sv
// Shared definitions for the sonar sweep controller: state codes, frame layout, ASCII constants.
package sonar_ctrl_pkg;

  typedef enum logic [3:0] {
    StIdle         = 4'd0,
    StSettle       = 4'd1,
    StMedir        = 4'd2,
    StEsperaMedida = 4'd3,
    StTxChar       = 4'd4,
    StEsperaTx     = 4'd5,
    StProxPos      = 4'd6
  } estado_t;

  localparam int unsigned FRAME_LEN   = 6;
  localparam logic [6:0]  ASCII_ZERO  = 7'h30;
  localparam logic [6:0]  ASCII_COMMA = 7'h2C;
  localparam logic [6:0]  ASCII_HASH  = 7'h23;

  // Frame layout: <pos> ',' <centena> <dezena> <unidade> '#'
  function automatic logic [6:0] frame_char(input logic [2:0]  idx,
                                            input logic [2:0]  pos,
                                            input logic [11:0] bcd);
    logic [6:0] ch;
    case (idx)
      3'd0:    ch = ASCII_ZERO + {4'b0000, pos};
      3'd1:    ch = ASCII_COMMA;
      3'd2:    ch = ASCII_ZERO + {3'b000, bcd[11:8]};
      3'd3:    ch = ASCII_ZERO + {3'b000, bcd[7:4]};
      3'd4:    ch = ASCII_ZERO + {3'b000, bcd[3:0]};
      3'd5:    ch = ASCII_HASH;
      default: ch = 7'h00;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo counter with synchronous clear, enable and an end-of-count flag at a runtime limit.
module contador_m #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [Width-1:0] limit_i,
  output logic             end_o
);

  logic [Width-1:0] count_d, count_q;

  assign end_o = (count_q == limit_i);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = end_o ? '0 : count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sonar_sweep_ctrl.sv
// Sonar sweep controller: settle servo, measure, send a 6-char ASCII frame, step position.
// Optional measurement timeout enabled by defining SONAR_TIMEOUT_EN.
module sonar_sweep_ctrl #(
  parameter int unsigned N_POS          = 8,
  parameter int unsigned SETTLE_CYCLES  = 250_000,
  parameter int unsigned TIMEOUT_CYCLES = 1_500_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ligar,
  input  logic        movimento,
  input  logic        medida_pronto,
  input  logic [11:0] medida_bcd,
  input  logic        tx_pronto,
  output logic        medir,
  output logic [2:0]  posicao,
  output logic        tx_partida,
  output logic [6:0]  tx_dado,
  output logic        fim_posicao,
  output logic [3:0]  db_estado
);

  import sonar_ctrl_pkg::*;

  if (N_POS < 2 || N_POS > 8 || SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : gen_param_check
    $error("sonar_sweep_ctrl: parameter out of range");
  end

`ifdef SONAR_TIMEOUT_EN
  localparam int unsigned CntMax = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES
                                                                    : TIMEOUT_CYCLES;
`else
  localparam int unsigned CntMax = SETTLE_CYCLES;
`endif
  localparam int unsigned CntW    = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [2:0]  PosLast = 3'(N_POS - 1);
  localparam logic [2:0]  IdxLast = 3'(FRAME_LEN - 1);

  estado_t     state_d, state_q;
  logic [2:0]  pos_d, pos_q;
  logic        dir_up_d, dir_up_q;
  logic [2:0]  idx_d, idx_q;
  logic [11:0] frame_d, frame_q;

  logic            cnt_clear, cnt_enable, cnt_end;
  logic [CntW-1:0] cnt_limit;

`ifdef SONAR_TIMEOUT_EN
  // One counter serves both waits; the limit follows the state using it.
  assign cnt_limit = (state_q == StSettle) ? CntW'(SETTLE_CYCLES - 1)
                                           : CntW'(TIMEOUT_CYCLES - 1);
`else
  assign cnt_limit = CntW'(SETTLE_CYCLES - 1);
`endif

  contador_m #(
    .Width (CntW)
  ) u_contador (
    .clk_i    (clock),
    .rst_ni   (reset),
    .clear_i  (cnt_clear),
    .enable_i (cnt_enable),
    .limit_i  (cnt_limit),
    .end_o    (cnt_end)
  );

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    dir_up_d   = dir_up_q;
    idx_d      = idx_q;
    frame_d    = frame_q;
    cnt_clear  = 1'b1;
    cnt_enable = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ligar) state_d = StSettle;
      end
      StSettle: begin
        cnt_clear  = 1'b0;
        cnt_enable = 1'b1;
        if (cnt_end) state_d = StMedir;
      end
      StMedir: begin
        state_d = StEsperaMedida;
      end
      StEsperaMedida: begin
        if (medida_pronto) begin
          frame_d = medida_bcd;
          idx_d   = '0;
          state_d = StTxChar;
        end
`ifdef SONAR_TIMEOUT_EN
        else begin
          cnt_clear  = 1'b0;
          cnt_enable = 1'b1;
          if (cnt_end) begin
            frame_d = 12'h999;
            idx_d   = '0;
            state_d = StTxChar;
          end
        end
`endif
      end
      StTxChar: begin
        state_d = StEsperaTx;
      end
      StEsperaTx: begin
        if (tx_pronto) begin
          if (idx_q < IdxLast) begin
            idx_d   = idx_q + 3'd1;
            state_d = StTxChar;
          end else begin
            idx_d   = '0;
            state_d = StProxPos;
          end
        end
      end
      StProxPos: begin
        // Ping-pong sweep: endpoints are visited once per pass.
        if (movimento) begin
          if (dir_up_q) begin
            if (pos_q == PosLast) begin
              dir_up_d = 1'b0;
              pos_d    = pos_q - 3'd1;
            end else begin
              pos_d = pos_q + 3'd1;
            end
          end else begin
            if (pos_q == 3'd0) begin
              dir_up_d = 1'b1;
              pos_d    = pos_q + 3'd1;
            end else begin
              pos_d = pos_q - 3'd1;
            end
          end
        end
        state_d = ligar ? StSettle : StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      pos_q    <= '0;
      dir_up_q <= 1'b1;
      idx_q    <= '0;
      frame_q  <= '0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      dir_up_q <= dir_up_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
    end
  end

  assign medir       = (state_q == StMedir);
  assign tx_partida  = (state_q == StTxChar);
  assign fim_posicao = (state_q == StProxPos);
  assign posicao     = pos_q;
  assign db_estado   = state_q;
  assign tx_dado     = (state_q == StTxChar || state_q == StEsperaTx)
                       ? frame_char(idx_q, pos_q, frame_q) : 7'h00;

endmodule
